// File: rtl/line_fill_buffer_if.sv
// Cache-miss, store-snoop and pmem signals of the line fill buffer.
// master = cache/pmem side driving requests; slave = the buffer itself.
interface line_fill_buffer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
);
  logic                  req_read;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_resp;
  logic [LINE_WIDTH-1:0] line_out;
  logic                  buf_hit;
  logic                  st_en;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic                  pmem_read;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic                  pmem_resp;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic [CNT_WIDTH-1:0]  fill_count;

  modport master (
    output req_read, req_addr, st_en, st_addr, pmem_resp, pmem_rdata,
    input  req_resp, line_out, buf_hit, pmem_read, pmem_address, fill_count
  );

  modport slave (
    input  req_read, req_addr, st_en, st_addr, pmem_resp, pmem_rdata,
    output req_resp, line_out, buf_hit, pmem_read, pmem_address, fill_count
  );
endinterface

// File: rtl/line_fill_buffer.sv
// Single-entry line fill buffer: hits answer in the same cycle, misses 1 cycle after pmem_resp.
// Requester holds req_read until req_resp; pmem_read is held until pmem_resp and never abandoned.
module line_fill_buffer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input logic              clk,
  input logic              reset,
  line_fill_buffer_if.slave bus
);
  localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_valid;
  logic                  r_stale;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [TAG_WIDTH-1:0]  r_pend_tag;
  logic [LINE_WIDTH-1:0] r_line;
  logic [CNT_WIDTH-1:0]  r_fill_count;

  logic [TAG_WIDTH-1:0]  w_req_tag;
  logic [TAG_WIDTH-1:0]  w_st_tag;
  logic                  w_hit;
  logic                  w_st_tag_hit;
  logic                  w_st_pend_hit;
  logic                  w_stale_nxt;
  logic                  w_start_fetch;
  logic                  w_fill;
  logic                  w_unused;

  assign w_req_tag     = bus.req_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign w_st_tag      = bus.st_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign w_hit         = r_valid && (r_tag == w_req_tag);
  assign w_st_tag_hit  = bus.st_en && (w_st_tag == r_tag);
  assign w_st_pend_hit = bus.st_en && (w_st_tag == r_pend_tag);
  // A store landing in the same cycle as the fill still marks it stale.
  assign w_stale_nxt   = r_stale | w_st_pend_hit;
  assign w_unused      = ^{bus.req_addr[OFFSET_BITS-1:0], bus.st_addr[OFFSET_BITS-1:0]};

  assign bus.buf_hit      = w_hit;
  assign bus.line_out     = r_line;
  assign bus.fill_count   = r_fill_count;
  assign bus.pmem_address = {r_pend_tag, {OFFSET_BITS{1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_fetch = 1'b0;
    w_fill        = 1'b0;
    bus.req_resp  = 1'b0;
    bus.pmem_read = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_read) begin
          // A hit racing a store to the same line is demoted to a refetch.
          if (w_hit && !w_st_tag_hit) begin
            bus.req_resp = 1'b1;
          end else begin
            w_start_fetch = 1'b1;
            w_state_nxt   = FETCH;
          end
        end
      end
      FETCH: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          w_fill      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        bus.req_resp = bus.req_read && (w_req_tag == r_tag);
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_stale      <= 1'b0;
      r_tag        <= '0;
      r_pend_tag   <= '0;
      r_line       <= '0;
      r_fill_count <= '0;
    end else begin
      if (w_st_tag_hit) begin
        r_valid <= 1'b0;
      end
      if (w_start_fetch) begin
        r_pend_tag <= w_req_tag;
        r_stale    <= 1'b0;
      end else if ((r_state == FETCH) && w_st_pend_hit) begin
        r_stale <= 1'b1;
      end
      // Stale fills still replace the line so DONE can answer the older requester.
      if (w_fill) begin
        r_line  <= bus.pmem_rdata;
        r_tag   <= r_pend_tag;
        r_valid <= !w_stale_nxt;
        if (r_fill_count != {CNT_WIDTH{1'b1}}) begin
          r_fill_count <= r_fill_count + CNT_WIDTH'(1);
        end
      end
    end
  end
endmodule
